// File: rtl/saida.sv
// saida: output-side result buffer for the CPMath datapath.
//
// The processor pushes DATA_W-bit result words into a DEPTH-entry circular
// FIFO. Each rising edge of the user's pushbutton pops one word: the whole word
// is shown raw on output_value. Its low 16 bits are converted to five BCD
// digits by a serial double-dabble (one bit per cycle). The digits are then
// decoded to active-low 7-segment patterns.
//
// Ports:
//   clk          system clock, all state on posedge
//   reset        synchronous active-high reset
//   _input       word from the processor
//   switchWrite  write strobe; one push per cycle while high
//   switchNext   pushbutton level; a rising edge requests the next word
//   output_value word currently displayed (registered)
//   seg          5 digits x 7 segments, active-low gfedcba; [6:0] = units
//   haveData     FIFO not empty
//   full         FIFO holds DEPTH words
//   overflow     sticky: a write was dropped because the FIFO was full
//   busy         conversion in progress
//
// Handshake: there is no backpressure on either side. switchWrite is a
// fire-and-forget strobe. It is accepted when the FIFO is not full, or when a
// pop is accepted in the same cycle. Otherwise it is dropped and sets
// overflow. A pushbutton edge is honoured only when haveData=1 and the
// converter is idle; all other edges are discarded, not queued.
module saida #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] _input,
  input  logic              switchWrite,
  input  logic              switchNext,
  output logic [DATA_W-1:0] output_value,
  output logic [34:0]       seg,
  output logic              haveData,
  output logic              full,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  // Storage.
  logic [DATA_W-1:0] mem [DEPTH];

  // Registers.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [34:0]       seg_q, seg_d;
  logic              next_prev_q, next_prev_d;
  logic [15:0]       bin_q, bin_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [4:0]        iter_q, iter_d;

  // Combinational helpers.
  logic              have_data;
  logic              is_full;
  logic              pop_req;
  logic              pop_acc;
  logic              wr_acc;
  logic [19:0]       bcd_adj;
  logic [DATA_W-1:0] head;

  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign have_data = (count_q != '0);
  assign is_full   = (count_q == FULL_CNT);
  assign head      = mem[rptr_q];

  // FIFO control and pushbutton edge detection.
  always_comb begin
    next_prev_d = switchNext;
    pop_req     = switchNext && !next_prev_q;
    pop_acc     = pop_req && have_data && (state_q == IDLE);
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    wr_acc      = switchWrite && (!is_full || pop_acc);
    overflow_d  = overflow_q || (switchWrite && !wr_acc);
    wptr_d      = wr_acc  ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = pop_acc ? rptr_q + 1'b1 : rptr_q;
    count_d     = count_q;
    case ({wr_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Double-dabble adjust: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: next state and datapath.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    out_d   = out_q;
    seg_d   = seg_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (pop_acc) begin
          out_d   = head;
          bin_d   = head[15:0];
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d  = {bcd_adj[18:0], bin_q[15]};
        bin_d  = {bin_q[14:0], 1'b0};
        iter_d = iter_q + 5'd1;
        // The 16th shift happens on this edge.
        if (iter_q == 5'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        for (int i = 0; i < 5; i++) begin
          seg_d[i*7 +: 7] = decode_digit(bcd_q[i*4 +: 4]);
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      seg_q       <= '1;
      next_prev_q <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      seg_q       <= seg_d;
      next_prev_q <= next_prev_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
    end
  end

  // Storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wptr_q] <= _input;
    end
  end

  assign output_value = out_q;
  assign seg          = seg_q;
  assign haveData     = have_data;
  assign full         = is_full;
  assign overflow     = overflow_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_saida.sv
module tb_saida;

  localparam int DATA_W = 32;
  localparam logic [34:0] SEG_BLANK = '1;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] in_word;
  logic              switch_write;
  logic              switch_next;
  logic [DATA_W-1:0] output_value;
  logic [34:0]       seg;
  logic              have_data;
  logic              full;
  logic              overflow;
  logic              busy;

  int n_cmp;
  int n_err;
  logic [DATA_W-1:0] exp_q[$];

  saida #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    ._input      (in_word),
    .switchWrite (switch_write),
    .switchNext  (switch_next),
    .output_value(output_value),
    .seg         (seg),
    .haveData    (have_data),
    .full        (full),
    .overflow    (overflow),
    .busy        (busy)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference display model: decimal digits by division, table lookup.
  function automatic logic [34:0] seg_of(input logic [15:0] v);
    logic [6:0]  tbl [10];
    logic [34:0] r;
    int x;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    x = int'(v);
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*7 +: 7] = tbl[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  // Driver tasks. Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] w);
    in_word      = w;
    switch_write = 1'b1;
    step();
    switch_write = 1'b0;
  endtask

  // One-cycle press; returns just after the edge where the pop would happen.
  task automatic press();
    switch_next = 1'b1;
    step();
    switch_next = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s wait_idle: busy still %b after %0d cycles, want 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (output_value !== '0) begin n_err++; $display("FAIL reset output_value: got %h want 0", output_value); end
    n_cmp++; if (seg !== SEG_BLANK) begin n_err++; $display("FAIL reset seg: got %b want all 1s", seg); end
    n_cmp++; if (have_data !== 1'b0) begin n_err++; $display("FAIL reset haveData: got %b want 0", have_data); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_and_hold();
    int busy_cnt;
    write_word(32'd1234);
    write_word(32'd65535);
    write_word(32'd7);
    n_cmp++; if (have_data !== 1'b1) begin n_err++; $display("FAIL basic haveData: got %b want 1", have_data); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL basic full: got %b want 0", full); end
    // Press and hold for 40 cycles.
    switch_next = 1'b1;
    step();
    n_cmp++; if (output_value !== 32'd1234) begin n_err++; $display("FAIL basic output_value at T: got %0d want 1234", output_value); end
    busy_cnt = busy ? 1 : 0;
    repeat (16) begin
      step();
      if (busy) busy_cnt++;
    end
    n_cmp++; if (busy_cnt !== 17) begin n_err++; $display("FAIL basic busy cycles: got %0d want 17", busy_cnt); end
    n_cmp++; if (seg !== SEG_BLANK) begin n_err++; $display("FAIL basic seg before T+17: got %b want blank", seg); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic busy at T+17: got %b want 0", busy); end
    n_cmp++; if (seg !== 35'b1000000_1111001_0100100_0110000_0011001) begin n_err++; $display("FAIL basic seg 01234: got %b", seg); end
    repeat (23) step();
    n_cmp++; if (output_value !== 32'd1234) begin n_err++; $display("FAIL hold single pop: got %0d want 1234", output_value); end
    switch_next = 1'b0;
    step();
    press();
    n_cmp++; if (output_value !== 32'd65535) begin n_err++; $display("FAIL second pop value: got %0d want 65535", output_value); end
    wait_idle("second_pop");
    n_cmp++; if (seg !== seg_of(16'd65535)) begin n_err++; $display("FAIL second pop seg: got %b want %b", seg, seg_of(16'd65535)); end
  endtask

  task automatic test_press_busy();
    write_word(32'd100);
    step();
    press();
    n_cmp++; if (output_value !== 32'd7) begin n_err++; $display("FAIL busy_press pop 7: got %0d want 7", output_value); end
    step();
    step();
    press();
    n_cmp++; if (output_value !== 32'd7) begin n_err++; $display("FAIL busy_press ignored: got %0d want 7", output_value); end
    wait_idle("busy_press");
    n_cmp++; if (seg !== seg_of(16'd7)) begin n_err++; $display("FAIL busy_press seg: got %b want %b", seg, seg_of(16'd7)); end
    n_cmp++; if (have_data !== 1'b1) begin n_err++; $display("FAIL busy_press haveData kept: got %b want 1", have_data); end
    step();
    press();
    n_cmp++; if (output_value !== 32'd100) begin n_err++; $display("FAIL busy_press pop 100: got %0d want 100", output_value); end
    wait_idle("pop100");
    n_cmp++; if (have_data !== 1'b0) begin n_err++; $display("FAIL busy_press empty: got %b want 0", have_data); end
  endtask

  task automatic test_empty_press();
    step();
    press();
    repeat (20) step();
    n_cmp++; if (output_value !== 32'd100) begin n_err++; $display("FAIL empty_press output_value: got %0d want 100", output_value); end
    n_cmp++; if (seg !== seg_of(16'd100)) begin n_err++; $display("FAIL empty_press seg: got %b want %b", seg, seg_of(16'd100)); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_press busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < 17; i++) begin
      w = {16'(i + 1), 16'(i * 3001)};
      write_word(w);
      if (i < 16) exp_q.push_back(w);
      if (i == 14) begin
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL overflow full at 15: got %b want 0", full); end
      end
      if (i == 15) begin
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL overflow full at 16: got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL overflow early: got %b want 0", overflow); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow sticky set: got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      step();
      press();
      e = exp_q.pop_front();
      n_cmp++; if (output_value !== e) begin n_err++; $display("FAIL overflow pop %0d: got %h want %h", i, output_value, e); end
      wait_idle("overflow_pop");
      n_cmp++; if (seg !== seg_of(e[15:0])) begin n_err++; $display("FAIL overflow seg %0d: got %b want %b", i, seg, seg_of(e[15:0])); end
    end
    n_cmp++; if (have_data !== 1'b0) begin n_err++; $display("FAIL overflow drained: got %b want 0", have_data); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow held: got %b want 1", overflow); end
  endtask

  task automatic test_full_simul();
    logic [DATA_W-1:0] e;
    for (int i = 0; i < 16; i++) begin
      write_word(32'h0000_A000 + 32'(i));
      exp_q.push_back(32'h0000_A000 + 32'(i));
    end
    step();
    in_word      = 32'hBEEF_1234;
    switch_write = 1'b1;
    switch_next  = 1'b1;
    step();
    switch_write = 1'b0;
    switch_next  = 1'b0;
    e = exp_q.pop_front();
    exp_q.push_back(32'hBEEF_1234);
    n_cmp++; if (output_value !== e) begin n_err++; $display("FAIL full_simul pop: got %h want %h", output_value, e); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_simul count kept: full %b want 1", full); end
    wait_idle("full_simul");
    for (int i = 0; i < 16; i++) begin
      step();
      press();
      e = exp_q.pop_front();
      n_cmp++; if (output_value !== e) begin n_err++; $display("FAIL full_simul order %0d: got %h want %h", i, output_value, e); end
      wait_idle("full_simul_drain");
    end
    n_cmp++; if (have_data !== 1'b0) begin n_err++; $display("FAIL full_simul drained: got %b want 0", have_data); end
  endtask

  task automatic test_reset_mid();
    write_word(32'h0001_002A);
    press();
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    n_cmp++; if (seg !== SEG_BLANK) begin n_err++; $display("FAIL reset_mid seg: got %b want blank", seg); end
    n_cmp++; if (output_value !== '0) begin n_err++; $display("FAIL reset_mid output_value: got %h want 0", output_value); end
    n_cmp++; if (have_data !== 1'b0) begin n_err++; $display("FAIL reset_mid haveData: got %b want 0", have_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_mid overflow: got %b want 0", overflow); end
  endtask

  task automatic test_display_upper();
    write_word(32'h0001_002A);
    press();
    n_cmp++; if (output_value !== 32'h0001_002A) begin n_err++; $display("FAIL upper output_value: got %h want 0001002a", output_value); end
    wait_idle("upper");
    n_cmp++; if (seg !== 35'b1000000_1000000_1000000_0011001_0100100) begin n_err++; $display("FAIL upper seg 00042: got %b", seg); end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    in_word      = '0;
    switch_write = 1'b0;
    switch_next  = 1'b0;
    test_reset();
    test_basic_and_hold();
    test_press_busy();
    test_empty_press();
    test_overflow();
    test_full_simul();
    test_reset_mid();
    test_display_upper();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
